// File: rtl/adder_stim_checker_if.sv
// Adder bus between the stimulus/checker and the adder under test.
//   dut_a, dut_b, dut_cin : operands and carry-in driven to the adder
//   dut_sum, dut_cout     : adder response
// master = stimulus/checker side, slave = adder side.
interface adder_stim_checker_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] dut_a;
    logic [WIDTH-1:0] dut_b;
    logic             dut_cin;
    logic [WIDTH-1:0] dut_sum;
    logic             dut_cout;

    modport master (output dut_a, dut_b, dut_cin, input  dut_sum, dut_cout);
    modport slave  (input  dut_a, dut_b, dut_cin, output dut_sum, dut_cout);
endinterface

// File: rtl/adder_stim_checker.sv
// Stimulus generator and checker for a WIDTH-bit adder with LATENCY cycles
// of response delay. A run issues num_vec vectors (4 fixed corners, then
// LFSR-driven randoms), compares every response against an internally
// computed golden {cout,sum}, and reports pass/fail counts plus the index
// of the first mismatch.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   start, seed,      : run request; seed/num_vec captured when start is
//   num_vec             accepted in IDLE
//   bus (master)      : dut_a/dut_b/dut_cin out, dut_sum/dut_cout in
//   busy, done        : run in progress; one-cycle end-of-run pulse
//   pass_count,       : per-run saturating result counters
//   fail_count
//   first_fail_idx,   : index of the first mismatching vector of the run
//   first_fail_valid
module adder_stim_checker #(
    parameter int WIDTH   = 64,
    parameter int LATENCY = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     seed,
    input  logic [15:0]          num_vec,
    adder_stim_checker_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          pass_count,
    output logic [15:0]          fail_count,
    output logic [15:0]          first_fail_idx,
    output logic                 first_fail_valid
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB = ONE << (WIDTH - 1);
    // Right-shifting Galois taps for x^64+x^63+x^61+x^60+1, placed relative
    // to the MSB so the same polynomial shape applies at any WIDTH >= 5.
    localparam logic [WIDTH-1:0] TAPS = (ONE << (WIDTH - 1)) | (ONE << (WIDTH - 2)) |
                                        (ONE << (WIDTH - 4)) | (ONE << (WIDTH - 5));

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                    state;
    logic [WIDTH-1:0]          a_lfsr, b_lfsr;
    logic [15:0]               nv, idx;
    // Delay line: stage 0 holds the vector currently on the bus; stage
    // LATENCY is the one whose response is checked at this edge.
    logic [LATENCY:0]          vld_pipe;
    logic [LATENCY:0][WIDTH:0] exp_pipe;
    logic [LATENCY:0][15:0]    idx_pipe;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] x);
        return x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
    endfunction

    logic [15:0]      nxt_idx;
    logic [WIDTH-1:0] vec_a, vec_b, seed_a, seed_b;
    logic             vec_cin, nxt_rand, pending, issue_now;
    logic [WIDTH:0]   vec_gold, resp;

    always_comb begin
        nxt_idx  = (state == S_IDLE) ? 16'd0 : idx + 16'd1;
        nxt_rand = 1'b0;
        vec_a    = '0;
        vec_b    = '0;
        vec_cin  = 1'b0;
        case (nxt_idx)
            16'd0: vec_cin = 1'b0;
            16'd1: begin vec_a = '1;  vec_b = ONE; end
            16'd2: begin vec_a = '1;  vec_b = '1;  vec_cin = 1'b1; end
            16'd3: begin vec_a = MSB; vec_b = MSB; end
            default: begin
                nxt_rand = 1'b1;
                vec_a    = a_lfsr;
                vec_b    = b_lfsr;
                vec_cin  = a_lfsr[WIDTH-1] ^ b_lfsr[WIDTH-1];
            end
        endcase
        vec_gold = {1'b0, vec_a} + {1'b0, vec_b} + {{WIDTH{1'b0}}, vec_cin};
        resp     = {bus.dut_cout, bus.dut_sum};
        // An all-zero LFSR would lock up, so zero seeds become 1.
        seed_a   = (seed == '0)  ? ONE : seed;
        seed_b   = (~seed == '0) ? ONE : ~seed;
        // Anything still in stages below LATENCY means responses are owed.
        pending  = 1'b0;
        for (int k = 0; k < LATENCY; k++) pending = pending | vld_pipe[k];
        issue_now = ((state == S_IDLE) && start && (num_vec != 16'd0)) ||
                    ((state == S_ISSUE) && (idx != nv - 16'd1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            bus.dut_a        <= '0;
            bus.dut_b        <= '0;
            bus.dut_cin      <= 1'b0;
            pass_count       <= '0;
            fail_count       <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
            vld_pipe         <= '0;
            exp_pipe         <= '0;
            idx_pipe         <= '0;
            a_lfsr           <= ONE;
            b_lfsr           <= ONE;
            nv               <= '0;
            idx              <= '0;
        end else begin
            done <= 1'b0;
            for (int k = 1; k <= LATENCY; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                exp_pipe[k] <= exp_pipe[k-1];
                idx_pipe[k] <= idx_pipe[k-1];
            end
            vld_pipe[0] <= 1'b0;

            if (vld_pipe[LATENCY]) begin
                if (resp == exp_pipe[LATENCY]) begin
                    if (pass_count != 16'hFFFF) pass_count <= pass_count + 16'd1;
                end else begin
                    if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
                    if (!first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_idx   <= idx_pipe[LATENCY];
                    end
                end
            end

            case (state)
                S_IDLE: if (start) begin
                    nv               <= num_vec;
                    a_lfsr           <= seed_a;
                    b_lfsr           <= seed_b;
                    pass_count       <= '0;
                    fail_count       <= '0;
                    first_fail_idx   <= '0;
                    first_fail_valid <= 1'b0;
                    if (num_vec == 16'd0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= S_ISSUE;
                        busy  <= 1'b1;
                    end
                end
                S_ISSUE: if (idx == nv - 16'd1) state <= S_DRAIN;
                S_DRAIN: if (!pending) begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase

            // Vector 0 goes out on the accepting edge, so the ISSUE state
            // shows exactly one vector per cycle, 0..num_vec-1.
            if (issue_now) begin
                bus.dut_a   <= vec_a;
                bus.dut_b   <= vec_b;
                bus.dut_cin <= vec_cin;
                vld_pipe[0] <= 1'b1;
                exp_pipe[0] <= vec_gold;
                idx_pipe[0] <= nxt_idx;
                idx         <= nxt_idx;
                if (nxt_rand) begin
                    a_lfsr <= lfsr_step(a_lfsr);
                    b_lfsr <= lfsr_step(b_lfsr);
                end
            end
        end
    end
endmodule

// File: tb/tb_adder_stim_checker.sv
// Bench for adder_stim_checker: a LATENCY=0 instance against a combinational
// adder with selectable faults, plus LATENCY=3 and LATENCY=2 instances both
// facing a 3-stage registered adder.
module tb_adder_stim_checker;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start3, start2;
    logic [63:0] seed;
    logic [15:0] num_vec;
    int          mode;      // 0 ideal, 1 cout stuck at 0, 2 sum[0] flipped when a[1:0]==01
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    adder_stim_checker_if #(.WIDTH(64)) bus0 ();
    adder_stim_checker_if #(.WIDTH(64)) bus3 ();
    adder_stim_checker_if #(.WIDTH(64)) bus2 ();

    logic        busy0, done0, ffv0, busy3, done3, ffv3, busy2, done2, ffv2;
    logic [15:0] pass0, fail0, ffi0, pass3, fail3, ffi3, pass2, fail2, ffi2;

    adder_stim_checker #(.WIDTH(64), .LATENCY(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .seed(seed), .num_vec(num_vec), .bus(bus0),
        .busy(busy0), .done(done0), .pass_count(pass0), .fail_count(fail0),
        .first_fail_idx(ffi0), .first_fail_valid(ffv0));
    adder_stim_checker #(.WIDTH(64), .LATENCY(3)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .seed(seed), .num_vec(num_vec), .bus(bus3),
        .busy(busy3), .done(done3), .pass_count(pass3), .fail_count(fail3),
        .first_fail_idx(ffi3), .first_fail_valid(ffv3));
    adder_stim_checker #(.WIDTH(64), .LATENCY(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .seed(seed), .num_vec(num_vec), .bus(bus2),
        .busy(busy2), .done(done2), .pass_count(pass2), .fail_count(fail2),
        .first_fail_idx(ffi2), .first_fail_valid(ffv2));

    // Combinational adder with optional fault injection
    logic [64:0] g0, r0;
    always_comb begin
        g0 = {1'b0, bus0.dut_a} + {1'b0, bus0.dut_b} + {64'd0, bus0.dut_cin};
        r0 = g0;
        if (mode == 1) r0[64] = 1'b0;
        if (mode == 2 && bus0.dut_a[1:0] == 2'b01) r0[0] = ~r0[0];
    end
    assign bus0.dut_sum  = r0[63:0];
    assign bus0.dut_cout = r0[64];

    // 3-stage registered adders
    logic [64:0] p3 [3];
    logic [64:0] p2 [3];
    always @(posedge clk) begin
        p3[0] <= {1'b0, bus3.dut_a} + {1'b0, bus3.dut_b} + {64'd0, bus3.dut_cin};
        p3[1] <= p3[0];
        p3[2] <= p3[1];
        p2[0] <= {1'b0, bus2.dut_a} + {1'b0, bus2.dut_b} + {64'd0, bus2.dut_cin};
        p2[1] <= p2[0];
        p2[2] <= p2[1];
    end
    assign {bus3.dut_cout, bus3.dut_sum} = p3[2];
    assign {bus2.dut_cout, bus2.dut_sum} = p2[2];

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference model: the vector stream a run must produce and the results
    // the checker must report for a given adder fault mode.
    logic [63:0] qa[$], qb[$];
    logic        qc[$];

    function automatic logic [63:0] step(input logic [63:0] x);
        return x[0] ? ((x >> 1) ^ 64'hD800_0000_0000_0000) : (x >> 1);
    endfunction

    task automatic build_model(input logic [63:0] s, input logic [15:0] n, input int md,
                               output logic [15:0] p, output logic [15:0] f,
                               output logic v, output logic [15:0] fi);
        logic [63:0] ra, rb, va, vb;
        logic        vc;
        logic [64:0] g, r;
        qa.delete(); qb.delete(); qc.delete();
        ra = (s == 64'd0) ? 64'd1 : s;
        rb = (~s == 64'd0) ? 64'd1 : ~s;
        p = 0; f = 0; v = 1'b0; fi = 0;
        for (int i = 0; i < int'(n); i++) begin
            case (i)
                0: begin va = 64'd0; vb = 64'd0; vc = 1'b0; end
                1: begin va = '1; vb = 64'd1; vc = 1'b0; end
                2: begin va = '1; vb = '1; vc = 1'b1; end
                3: begin va = 64'h8000_0000_0000_0000; vb = va; vc = 1'b0; end
                default: begin
                    va = ra; vb = rb; vc = ra[63] ^ rb[63];
                    ra = step(ra); rb = step(rb);
                end
            endcase
            qa.push_back(va); qb.push_back(vb); qc.push_back(vc);
            g = {1'b0, va} + {1'b0, vb} + {64'd0, vc};
            r = g;
            if (md == 1) r[64] = 1'b0;
            if (md == 2 && va[1:0] == 2'b01) r[0] = ~r[0];
            if (r == g) p++;
            else begin
                f++;
                if (!v) begin v = 1'b1; fi = 16'(i); end
            end
        end
    endtask

    typedef struct {
        logic [63:0] seed;
        logic [15:0] nv;
        int          mode;
        logic [15:0] ep, ef;
        logic        ev;
        logic [15:0] ei;
    } vec_t;

    vec_t tbl [10];

    // One run on the LATENCY=0 instance; entered and left at a negedge.
    task automatic run0(input vec_t e);
        int          lat, k, j;
        logic        busy_seen;
        logic [15:0] mp, mf, mi;
        logic        mv;
        build_model(e.seed, e.nv, e.mode, mp, mf, mv, mi);
        mode = e.mode; seed = e.seed; num_vec = e.nv; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        lat = 1; k = 0; busy_seen = 1'b0;
        while (!done0 && lat < int'(e.nv) + 20) begin
            if (busy0) begin
                busy_seen = 1'b1;
                j = (k < int'(e.nv)) ? k : int'(e.nv) - 1;
                chk("operands", {95'd0, qc[j], qa[j], qb[j]},
                    {95'd0, bus0.dut_cin, bus0.dut_a, bus0.dut_b});
                k++;
            end
            // a start while busy must leave the run untouched
            if (k == 5) begin start0 = 1'b1; seed = ~e.seed; num_vec = 16'd3; end
            else start0 = 1'b0;
            @(negedge clk);
            lat++;
        end
        start0 = 1'b0;
        chk("done_seen", 160'(done0), 160'd1);
        if (e.nv == 16'd0) begin
            chk("zero_lat", 160'(lat), 160'd1);
            chk("zero_busy", 160'(busy_seen), 160'd0);
        end
        chk("pass", 160'(pass0), 160'(e.ep));
        chk("fail", 160'(fail0), 160'(e.ef));
        chk("ffv", 160'(ffv0), 160'(e.ev));
        chk("ffi", 160'(ffi0), 160'(e.ei));
        @(negedge clk);
        chk("done_width", 160'(done0), 160'd0);
        chk("pass_hold", 160'(pass0), 160'(e.ep));
        chk("fail_hold", 160'(fail0), 160'(e.ef));
    endtask

    initial begin
        int          lat, lat3, lat2;
        logic [15:0] mp, mf, mi;
        logic        mv;
        vec_t        e;
        rst_n = 1'b0; start0 = 1'b0; start3 = 1'b0; start2 = 1'b0;
        seed = '0; num_vec = '0; mode = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 160'(busy0), 160'd0);
        chk("rst_done", 160'(done0), 160'd0);
        chk("rst_ops", {95'd0, bus0.dut_cin, bus0.dut_a, bus0.dut_b}, 160'd0);
        chk("rst_cnt", {112'd0, pass0, fail0, ffi0}, 160'd0);
        chk("rst_ffv", 160'(ffv0), 160'd0);
        chk("rst_busy3", 160'(busy3), 160'd0);
        rst_n = 1'b1;
        @(negedge clk);

        tbl[0] = '{64'h1234, 16'd100, 0, 16'd100, 16'd0, 1'b0, 16'd0};
        tbl[1] = '{64'h9876_5432_10FE_DCBA, 16'd4, 0, 16'd4, 16'd0, 1'b0, 16'd0};
        tbl[2] = '{64'h1234, 16'd4, 1, 16'd1, 16'd3, 1'b1, 16'd1};
        tbl[3] = '{64'h1234, 16'd0, 0, 16'd0, 16'd0, 1'b0, 16'd0};
        tbl[4] = '{64'h1234, 16'd1, 1, 16'd1, 16'd0, 1'b0, 16'd0};
        for (int i = 5; i < 10; i++) begin
            case (i)
                5: tbl[i].seed = 64'd0;
                6: tbl[i].seed = '1;
                default: tbl[i].seed = {$urandom, $urandom};
            endcase
            tbl[i].nv   = 16'($urandom_range(5, 60));
            tbl[i].mode = 2;
            build_model(tbl[i].seed, tbl[i].nv, 2, mp, mf, mv, mi);
            tbl[i].ep = mp; tbl[i].ef = mf; tbl[i].ev = mv; tbl[i].ei = mi;
        end
        for (int i = 0; i < 10; i++) run0(tbl[i]);

        // LATENCY=3 vs LATENCY=2 against the same 3-stage adder
        seed = 64'hCAFE_F00D_1234_5678; num_vec = 16'd20;
        start3 = 1'b1; start2 = 1'b1;
        @(negedge clk);
        start3 = 1'b0; start2 = 1'b0;
        lat = 1; lat3 = 0; lat2 = 0;
        while ((lat3 == 0 || lat2 == 0) && lat < 80) begin
            if (done3 && lat3 == 0) lat3 = lat;
            if (done2 && lat2 == 0) lat2 = lat;
            @(negedge clk);
            lat++;
        end
        // last vector is on the bus in cycle 20; three more cycles, then DONE
        chk("l3_done_cycle", 160'(lat3), 160'd24);
        chk("l3_pass", 160'(pass3), 160'd20);
        chk("l3_fail", 160'(fail3), 160'd0);
        chk("l2_fails", 160'(fail2 != 16'd0), 160'd1);
        chk("l2_done_seen", 160'(lat2 != 0), 160'd1);

        // reset while vector 10 of a 50-vector run is on the bus
        build_model(64'h55AA, 16'd50, 0, mp, mf, mv, mi);
        mode = 0; seed = 64'h55AA; num_vec = 16'd50; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_rst_vec10", 160'(bus0.dut_a), 160'(qa[10]));
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 160'(busy0), 160'd0);
        chk("mid_rst_done", 160'(done0), 160'd0);
        chk("mid_rst_ops", {95'd0, bus0.dut_cin, bus0.dut_a, bus0.dut_b}, 160'd0);
        chk("mid_rst_cnt", {111'd0, ffv0, pass0, fail0, ffi0}, 160'd0);
        rst_n = 1'b1;
        e = '{64'h0BAD_BEEF, 16'd12, 0, 16'd0, 16'd0, 1'b0, 16'd0};
        build_model(e.seed, e.nv, 0, mp, mf, mv, mi);
        e.ep = mp; e.ef = mf; e.ev = mv; e.ei = mi;
        run0(e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adder_stim_checker.md
ADDER_STIM_CHECKER -- requirements
Module: adder_stim_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand width driven to the adder under test.
REQ-002 SHALL have parameter LATENCY, default 0, adder response delay in cycles (legal 0..7).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port start  input  1  begins a run when sampled high in IDLE.
REQ-006 SHALL have port seed  input  WIDTH  LFSR seed, captured on accepted start.
REQ-007 SHALL have port num_vec  input  16  vectors per run, captured on accepted start.
REQ-008 SHALL have ports dut_a, dut_b  output  WIDTH  registered operands to the adder.
REQ-009 SHALL have port dut_cin  output  1  registered carry-in to the adder.
REQ-010 SHALL have port dut_sum  input  WIDTH  adder sum response.
REQ-011 SHALL have port dut_cout  input  1  adder carry-out response.
REQ-012 SHALL have ports busy, done  output  1  run in progress; one-cycle end-of-run pulse.
REQ-013 SHALL have ports pass_count, fail_count  output  16  per-run result counters.
REQ-014 SHALL have ports first_fail_idx  output  16, first_fail_valid  output  1  index of first mismatching vector.

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
REQ-016 IDLE: start=1 SHALL capture seed/num_vec, clear counters and first_fail_*, go ISSUE; if num_vec=0 go DONE directly.
REQ-017 ISSUE: SHALL drive exactly one new vector per cycle, index 0..num_vec-1; after index num_vec-1 go DRAIN.
REQ-018 DRAIN: SHALL hold last vector on outputs and go DONE when no expected result remains in the delay line.
REQ-019 DONE: done SHALL be 1 for exactly this one cycle; next state IDLE.
REQ-020 busy SHALL be 1 in ISSUE and DRAIN, 0 in IDLE and DONE; start SHALL be ignored when not IDLE.
REQ-021 Vectors 0..3 SHALL be fixed corners: (0,0,0); (all-ones,1,0); (all-ones,all-ones,1); (MSB-only,MSB-only,0).
REQ-022 Vectors >=4 SHALL come from two WIDTH-bit Galois LFSRs, poly x^64+x^63+x^61+x^60+1, seeded seed and ~seed; zero seed SHALL be replaced by 1.
REQ-023 LFSRs SHALL advance once per issued random vector; dut_cin = a_lfsr[WIDTH-1] XOR b_lfsr[WIDTH-1].
REQ-024 Golden {cout,sum} SHALL be the WIDTH+1-bit result of a+b+cin, computed internally.
REQ-025 Vector driven during cycle c SHALL be compared at the rising edge ending cycle c+LATENCY via a LATENCY+1 deep valid/expected delay line.
REQ-026 Match of {dut_cout,dut_sum} vs golden SHALL increment pass_count, else fail_count; both saturate at 16'hFFFF.
REQ-027 On first mismatch of a run, SHALL latch its index in first_fail_idx and set first_fail_valid; later mismatches SHALL not update it.
REQ-028 Counters and first_fail_* SHALL hold their values from DONE until the next accepted start.
REQ-029 Comparisons SHALL occur only for valid delay-line entries; no compare in IDLE/DONE.

Reset
REQ-030 rst_n=0 at a rising edge SHALL force IDLE, busy=0, done=0, dut_a=dut_b=0, dut_cin=0, counters=0, first_fail_idx=0, first_fail_valid=0, delay line invalid.
REQ-031 Reset mid-run SHALL abandon the run with no done pulse; start in the first cycle after rst_n rises SHALL be accepted.

Verification
REQ-032 Ideal combinational adder, LATENCY=0, num_vec=100, seed=64'h1234 -> done after 100 issue cycles, pass_count=100, fail_count=0, first_fail_valid=0.
REQ-033 num_vec=4 -> operands exactly the REQ-021 corners; golden {cout,sum} = {0,0},{1,0},{1,all-ones},{1,0}; pass_count=4.
REQ-034 Adder with cout stuck at 0, num_vec=4 -> fail_count=3, first_fail_idx=1, first_fail_valid=1.
REQ-035 LATENCY=3 with 3-stage registered adder, num_vec=20 -> pass_count=20, done exactly 3 cycles after last vector issued plus DONE entry; LATENCY=2 with same adder -> fail_count>0.
REQ-036 num_vec=0 -> done pulses one cycle after start, busy never 1, counters 0; start during busy ignored.
REQ-037 rst_n low for one cycle at vector 10 of a 50-vector run -> all outputs at REQ-030 values, no done; new start completes normally.
